// File: rtl/cntr_ctrl.sv
// cntr_ctrl: start/stop/pause controlled up-counter with terminal detect.
// Runs from load_val up to term_val (wrapping modulo 2^WIDTH), pulses done
// for one cycle on completion, then returns to IDLE.
// Compile-time option: define CNTR_CTRL_AUTORELOAD_EN to make DONE reload
// load_val and re-enter RUN, giving periodic done pulses until stop.
module cntr_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_term_hit;

    assign w_term_hit = (r_count == term_val);

    // Next-state and next-count: stop beats start beats pause; terminal beats pause.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = load_val;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (w_term_hit) begin
                        w_state_nxt = ST_DONE;
                    end else if (pause) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef CNTR_CTRL_AUTORELOAD_EN
                    w_state_nxt = ST_RUN;
                    w_count_nxt = load_val;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, count and decoded status flags; flags track the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HOLD);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_cntr_ctrl.sv
// tb_cntr_ctrl: scoreboard bench for cntr_ctrl. Each driven cycle pushes the
// expected post-edge state/count/busy/done; it is popped and compared #1 after
// the edge. Works in both the default and CNTR_CTRL_AUTORELOAD_EN builds.
module tb_cntr_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] cnt;
        logic       bsy;
        logic       dn;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] load_val;
    logic [7:0] term_val;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [1:0] state;

    exp_t       exp_q[$];
    logic [1:0] m_state;
    logic [7:0] m_count;
    int         n_checks;
    int         n_pass;

    cntr_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .load_val (load_val),
        .term_val (term_val),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input logic [7:0] cnt);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        e.bsy = (st == S_RUN) || (st == S_HOLD);
        e.dn  = (st == S_DONE);
        return e;
    endfunction

    // Behavioural reference of one clock edge, from the bench's own expected state.
    function automatic exp_t model_next(input logic st_i, input logic sp_i, input logic ps_i,
                                        input logic [7:0] lv, input logic [7:0] tv);
        logic [1:0] ns;
        logic [7:0] nc;
        ns = m_state;
        nc = m_count;
        if (sp_i) begin
            ns = S_IDLE;
        end else if (st_i) begin
            ns = S_RUN;
            nc = lv;
        end else if (m_state == S_RUN) begin
            if (m_count == tv)  ns = S_DONE;
            else if (ps_i)      ns = S_HOLD;
            else                nc = 8'(m_count + 8'd1);
        end else if (m_state == S_HOLD) begin
            if (!ps_i) ns = S_RUN;
        end else if (m_state == S_DONE) begin
`ifdef CNTR_CTRL_AUTORELOAD_EN
            ns = S_RUN;
            nc = lv;
`else
            ns = S_IDLE;
`endif
        end
        return mk(ns, nc);
    endfunction

    task automatic step(input string tag, input logic st_i, input logic sp_i, input logic ps_i,
                        input logic [7:0] lv, input logic [7:0] tv, input exp_t e);
        exp_t got;
        start    = st_i;
        stop     = sp_i;
        pause    = ps_i;
        load_val = lv;
        term_val = tv;
        exp_q.push_back(e);
        m_state = e.st;
        m_count = e.cnt;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".state"}, 32'(state), 32'(got.st));
        check({tag, ".count"}, 32'(count), 32'(got.cnt));
        check({tag, ".busy"},  32'(busy),  32'(got.bsy));
        check({tag, ".done"},  32'(done),  32'(got.dn));
    endtask

    task automatic step_m(input string tag, input logic st_i, input logic sp_i, input logic ps_i,
                          input logic [7:0] lv, input logic [7:0] tv);
        step(tag, st_i, sp_i, ps_i, lv, tv, model_next(st_i, sp_i, ps_i, lv, tv));
    endtask

    initial begin
        exp_t basic_seq[7];
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        load_val = 8'h00;
        term_val = 8'h00;
        m_state  = S_IDLE;
        m_count  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.state", 32'(state), 32'(S_IDLE));
        check("reset.count", 32'(count), 32'h0);
        check("reset.busy",  32'(busy),  32'h0);
        check("reset.done",  32'(done),  32'h0);

        // Idle after reset with no start: stays IDLE, count 0.
        step("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'h55, 8'h66, mk(S_IDLE, 8'h00));
        step("post_reset_idle", 1'b0, 1'b0, 1'b1, 8'h55, 8'h66, mk(S_IDLE, 8'h00));

        // Basic run 3..7 with fixed expected table.
        basic_seq[0] = mk(S_RUN, 8'd4);
        basic_seq[1] = mk(S_RUN, 8'd5);
        basic_seq[2] = mk(S_RUN, 8'd6);
        basic_seq[3] = mk(S_RUN, 8'd7);
        basic_seq[4] = mk(S_DONE, 8'd7);
`ifdef CNTR_CTRL_AUTORELOAD_EN
        basic_seq[5] = mk(S_RUN, 8'd3);
        basic_seq[6] = mk(S_IDLE, 8'd3);
`else
        basic_seq[5] = mk(S_IDLE, 8'd7);
        basic_seq[6] = mk(S_IDLE, 8'd7);
`endif
        step("basic", 1'b1, 1'b0, 1'b0, 8'd3, 8'd7, mk(S_RUN, 8'd3));
        for (int i = 0; i < 6; i++) begin
            step($sformatf("basic%0d", i), 1'b0, 1'b0, 1'b0, 8'd3, 8'd7, basic_seq[i]);
        end
        step("basic_stop", 1'b0, 1'b1, 1'b0, 8'd3, 8'd7, basic_seq[6]);

        // Wrap FE,FF,00,01 then done.
        step("wrap", 1'b1, 1'b0, 1'b0, 8'hFE, 8'h01, mk(S_RUN, 8'hFE));
        step("wrap", 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01, mk(S_RUN, 8'hFF));
        step("wrap", 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01, mk(S_RUN, 8'h00));
        step("wrap", 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01, mk(S_RUN, 8'h01));
        step("wrap", 1'b0, 1'b0, 1'b0, 8'hFE, 8'h01, mk(S_DONE, 8'h01));
        step("wrap_stop", 1'b0, 1'b1, 1'b0, 8'hFE, 8'h01, mk(S_IDLE, 8'h01));

        // Pause at count 4 for three cycles, then resume to done.
        step_m("pause", 1'b1, 1'b0, 1'b0, 8'd0, 8'd10);
        for (int i = 0; i < 4; i++) step_m("pause_run", 1'b0, 1'b0, 1'b0, 8'd0, 8'd10);
        for (int i = 0; i < 3; i++)
            step("pause_hold", 1'b0, 1'b0, 1'b1, 8'd0, 8'd10, mk(S_HOLD, 8'd4));
        step("pause_resume", 1'b0, 1'b0, 1'b0, 8'd0, 8'd10, mk(S_RUN, 8'd4));
        for (int i = 0; i < 7; i++) step_m("pause_tail", 1'b0, 1'b0, 1'b0, 8'd0, 8'd10);
        step("pause_done_reached", 1'b0, 1'b1, 1'b0, 8'd0, 8'd10, mk(S_IDLE, m_count));

        // Stop and start together at count 5: stop wins.
        step_m("prio", 1'b1, 1'b0, 1'b0, 8'd0, 8'd20);
        for (int i = 0; i < 5; i++) step_m("prio_run", 1'b0, 1'b0, 1'b0, 8'd0, 8'd20);
        step("prio_stop_start", 1'b1, 1'b1, 1'b1, 8'd9, 8'd20, mk(S_IDLE, 8'd5));
        step("idle_hold", 1'b0, 1'b0, 1'b0, 8'd9, 8'd20, mk(S_IDLE, 8'd5));

        // Restart mid-run reloads.
        step_m("restart", 1'b1, 1'b0, 1'b0, 8'd10, 8'd40);
        step_m("restart", 1'b0, 1'b0, 1'b0, 8'd10, 8'd40);
        step("restart_mid", 1'b1, 1'b0, 1'b0, 8'd30, 8'd40, mk(S_RUN, 8'd30));
        step("restart_stop", 1'b0, 1'b1, 1'b0, 8'd30, 8'd40, mk(S_IDLE, 8'd30));

        // load==term: one RUN cycle then DONE; terminal beats pause.
        step("eq", 1'b1, 1'b0, 1'b0, 8'd9, 8'd9, mk(S_RUN, 8'd9));
        step("eq_term_over_pause", 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, mk(S_DONE, 8'd9));
        step("eq_stop", 1'b0, 1'b1, 1'b0, 8'd9, 8'd9, mk(S_IDLE, 8'd9));

        // Autoreload period check (acts as plain run in default build).
        step_m("reload", 1'b1, 1'b0, 1'b0, 8'd2, 8'd4);
        for (int i = 0; i < 9; i++) step_m("reload", 1'b0, 1'b0, 1'b0, 8'd2, 8'd4);
        step_m("reload_stop", 1'b0, 1'b1, 1'b0, 8'd2, 8'd4);

        // Async reset mid-run at count 6.
        step_m("areset", 1'b1, 1'b0, 1'b0, 8'd0, 8'd50);
        for (int i = 0; i < 6; i++) step_m("areset_run", 1'b0, 1'b0, 1'b0, 8'd0, 8'd50);
        check("areset_pre.count", 32'(count), 32'd6);
        reset = 1'b1;
        #1;
        check("areset.state", 32'(state), 32'(S_IDLE));
        check("areset.count", 32'(count), 32'h0);
        check("areset.busy",  32'(busy),  32'h0);
        check("areset.done",  32'(done),  32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_state = S_IDLE;
        m_count = 8'h00;
        step("areset_idle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd50, mk(S_IDLE, 8'h00));
        step("areset_idle", 1'b0, 1'b0, 1'b1, 8'd0, 8'd50, mk(S_IDLE, 8'h00));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
